// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter with a registered IDLE/GRANT0/GRANT1 FSM.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise master 1 always wins ties.
module bus_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_data_wr,
    input  logic [3:0]            m0_mask,
    output logic                  m0_stall,
    output logic [DATA_WIDTH-1:0] m0_data_rd,
    output logic [DATA_WIDTH-1:0] m0_data_rd_2,

    input  logic [DATA_WIDTH-1:0] m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_data_wr,
    input  logic [3:0]            m1_mask,
    output logic                  m1_stall,
    output logic [DATA_WIDTH-1:0] m1_data_rd,
    output logic [DATA_WIDTH-1:0] m1_data_rd_2,

    output logic [DATA_WIDTH-1:0] s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_data_wr,
    output logic [3:0]            s_mask,
    input  logic                  s_stall,
    input  logic [DATA_WIDTH-1:0] s_data_rd,
    input  logic [DATA_WIDTH-1:0] s_data_rd_2
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic m0_req;
    logic m1_req;
    logic pick_m1;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    // Remembers which master was granted last; reset value makes master 1 win the first tie.
    logic last_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && state_next == GRANT0) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && state_next == GRANT1) begin
            last_grant <= 1'b1;
        end
    end

    assign pick_m1 = ~last_grant;
`else
    assign pick_m1 = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A grant ends on completion (unstalled cycle) or abort (request dropped);
    // it only persists while the slave stalls and the owner keeps requesting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_next = pick_m1 ? GRANT1 : GRANT0;
                end else if (m1_req) begin
                    state_next = GRANT1;
                end else if (m0_req) begin
                    state_next = GRANT0;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT0: begin
                if (m0_req && s_stall) begin
                    state_next = GRANT0;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                if (m1_req && s_stall) begin
                    state_next = GRANT1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Any requesting master that does not own the bus is stalled, including in IDLE.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_data_wr    = '0;
        s_mask       = 4'h0;
        m0_stall     = m0_req;
        m1_stall     = m1_req;
        m0_data_rd   = '0;
        m0_data_rd_2 = '0;
        m1_data_rd   = '0;
        m1_data_rd_2 = '0;
        case (state)
            GRANT0: begin
                s_address    = m0_address;
                s_read       = m0_read;
                s_write      = m0_write;
                s_data_wr    = m0_data_wr;
                s_mask       = m0_mask;
                m0_stall     = m0_req & s_stall;
                m0_data_rd   = s_data_rd;
                m0_data_rd_2 = s_data_rd_2;
            end
            GRANT1: begin
                s_address    = m1_address;
                s_read       = m1_read;
                s_write      = m1_write;
                s_data_wr    = m1_data_wr;
                s_mask       = m1_mask;
                m1_stall     = m1_req & s_stall;
                m1_data_rd   = s_data_rd;
                m1_data_rd_2 = s_data_rd_2;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; expectations follow BUS_ARBITER_ROUND_ROBIN_EN if defined.
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_address, m0_data_wr, m0_data_rd, m0_data_rd_2;
    logic        m0_read, m0_write, m0_stall;
    logic [3:0]  m0_mask;
    logic [31:0] m1_address, m1_data_wr, m1_data_rd, m1_data_rd_2;
    logic        m1_read, m1_write, m1_stall;
    logic [3:0]  m1_mask;
    logic [31:0] s_address, s_data_wr, s_data_rd, s_data_rd_2;
    logic        s_read, s_write, s_stall;
    logic [3:0]  s_mask;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_data_wr(m0_data_wr), .m0_mask(m0_mask), .m0_stall(m0_stall),
        .m0_data_rd(m0_data_rd), .m0_data_rd_2(m0_data_rd_2),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_data_wr(m1_data_wr), .m1_mask(m1_mask), .m1_stall(m1_stall),
        .m1_data_rd(m1_data_rd), .m1_data_rd_2(m1_data_rd_2),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_data_wr(s_data_wr), .s_mask(s_mask), .s_stall(s_stall),
        .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_data_wr = '0; m0_mask = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_data_wr = '0; m1_mask = '0;
        s_stall = 0; s_data_rd = '0; s_data_rd_2 = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m0_read = 1'b1;
        m0_address = 32'h0000_0AAA;
        tick();
        tick();
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_read got %0h want 0", s_read); end
        checks++; if (s_mask !== 4'h0) begin errors++; $display("[TB] FAIL reset_s_mask got %0h want 0", s_mask); end
        checks++; if (s_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_s_address got %0h want 0", s_address); end
        checks++; if (m0_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_m0_stall_req got %0h want 1", m0_stall); end
        checks++; if (m1_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_stall got %0h want 0", m1_stall); end
        m0_read = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        clear_inputs();
        m0_read = 1'b1;
        m0_address = 32'h1FC0_0000;
        s_data_rd = 32'h1234_5678;
        s_data_rd_2 = 32'hA5A5_A5A5;
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_s_read got %0h want 0", s_read); end
        checks++; if (m0_data_rd !== 32'h0) begin errors++; $display("[TB] FAIL single_idle_m0_data_rd got %0h want 0", m0_data_rd); end
        tick();
        checks++; if (s_read !== 1'b1) begin errors++; $display("[TB] FAIL single_grant_s_read got %0h want 1", s_read); end
        checks++; if (s_address !== 32'h1FC0_0000) begin errors++; $display("[TB] FAIL single_grant_s_address got %0h want 1fc00000", s_address); end
        checks++; if (m0_stall !== 1'b0) begin errors++; $display("[TB] FAIL single_grant_m0_stall got %0h want 0", m0_stall); end
        checks++; if (m0_data_rd !== 32'h1234_5678) begin errors++; $display("[TB] FAIL single_m0_data_rd got %0h want 12345678", m0_data_rd); end
        checks++; if (m0_data_rd_2 !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL single_m0_data_rd_2 got %0h want a5a5a5a5", m0_data_rd_2); end
        checks++; if (m1_data_rd !== 32'h0) begin errors++; $display("[TB] FAIL single_m1_data_rd got %0h want 0", m1_data_rd); end
        tick();
        checks++; if (s_read !== 1'b0) begin errors++; $display("[TB] FAIL single_back_to_idle_s_read got %0h want 0", s_read); end
        checks++; if (m0_data_rd !== 32'h0) begin errors++; $display("[TB] FAIL single_idle_data_rd got %0h want 0", m0_data_rd); end
        clear_inputs();
        tick();
    endtask

    task automatic test_stalled_write();
        clear_inputs();
        m1_write = 1'b1;
        m1_address = 32'h0000_2000;
        m1_data_wr = 32'hDEAD_BEEF;
        m1_mask = 4'hF;
        s_stall = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_write !== 1'b1) begin errors++; $display("[TB] FAIL stall_s_write[%0d] got %0h want 1", i, s_write); end
            checks++; if (s_data_wr !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL stall_s_data_wr[%0d] got %0h want deadbeef", i, s_data_wr); end
            checks++; if (s_mask !== 4'hF) begin errors++; $display("[TB] FAIL stall_s_mask[%0d] got %0h want f", i, s_mask); end
            checks++; if (m1_stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_m1_stall[%0d] got %0h want 1", i, m1_stall); end
            tick();
        end
        s_stall = 1'b0;
        #1;
        checks++; if (s_write !== 1'b1) begin errors++; $display("[TB] FAIL stall_4th_s_write got %0h want 1", s_write); end
        checks++; if (m1_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_4th_m1_stall got %0h want 0", m1_stall); end
        tick();
        checks++; if (s_write !== 1'b0) begin errors++; $display("[TB] FAIL stall_done_s_write got %0h want 0", s_write); end
        clear_inputs();
        tick();
    endtask

    task automatic test_contention();
        logic        exp_m1;
        logic [31:0] exp_addr;
        clear_inputs();
        do_reset();
        m0_read = 1'b1; m0_address = 32'h0000_0100;
        m1_read = 1'b1; m1_address = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            exp_m1 = (t % 2 == 0);
`else
            exp_m1 = 1'b1;
`endif
            exp_addr = exp_m1 ? 32'h0000_0200 : 32'h0000_0100;
            tick();
            checks++; if (s_address !== exp_addr) begin errors++; $display("[TB] FAIL contend_grant[%0d] got %0h want %0h", t, s_address, exp_addr); end
            checks++; if (m0_stall !== exp_m1) begin errors++; $display("[TB] FAIL contend_m0_stall[%0d] got %0h want %0h", t, m0_stall, exp_m1); end
            checks++; if (m1_stall !== !exp_m1) begin errors++; $display("[TB] FAIL contend_m1_stall[%0d] got %0h want %0h", t, m1_stall, !exp_m1); end
            tick();
            checks++; if (s_read !== 1'b0) begin errors++; $display("[TB] FAIL contend_idle_s_read[%0d] got %0h want 0", t, s_read); end
            checks++; if (m0_stall !== 1'b1) begin errors++; $display("[TB] FAIL contend_idle_m0_stall[%0d] got %0h want 1", t, m0_stall); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort();
        clear_inputs();
        do_reset();
        m0_read = 1'b1; m0_address = 32'h0000_0300;
        s_stall = 1'b1;
        tick();
        checks++; if (s_address !== 32'h0000_0300) begin errors++; $display("[TB] FAIL abort_grant0_addr got %0h want 300", s_address); end
        m1_read = 1'b1; m1_address = 32'h0000_0400;
        #1;
        checks++; if (m1_stall !== 1'b1) begin errors++; $display("[TB] FAIL abort_m1_pending_stall got %0h want 1", m1_stall); end
        tick();
        m0_read = 1'b0;
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("[TB] FAIL abort_same_cycle_s_read got %0h want 0", s_read); end
        checks++; if (m0_stall !== 1'b0) begin errors++; $display("[TB] FAIL abort_m0_stall got %0h want 0", m0_stall); end
        tick();
        checks++; if (s_read !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_s_read got %0h want 0", s_read); end
        checks++; if (m1_stall !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle_m1_stall got %0h want 1", m1_stall); end
        tick();
        checks++; if (s_read !== 1'b1) begin errors++; $display("[TB] FAIL abort_m1_grant_s_read got %0h want 1", s_read); end
        checks++; if (s_address !== 32'h0000_0400) begin errors++; $display("[TB] FAIL abort_m1_grant_addr got %0h want 400", s_address); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_in_grant();
        clear_inputs();
        do_reset();
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 32'h0000_0700;
        s_stall = 1'b1;
        tick();
        checks++; if (s_read !== 1'b1 || s_write !== 1'b1) begin errors++; $display("[TB] FAIL rstgrant_pre got rd=%0h wr=%0h want 1 1", s_read, s_write); end
        rst_n = 1'b0;
        tick();
        checks++; if (s_read !== 1'b0) begin errors++; $display("[TB] FAIL rstgrant_s_read got %0h want 0", s_read); end
        checks++; if (s_write !== 1'b0) begin errors++; $display("[TB] FAIL rstgrant_s_write got %0h want 0", s_write); end
        checks++; if (m1_stall !== 1'b1) begin errors++; $display("[TB] FAIL rstgrant_m1_stall got %0h want 1", m1_stall); end
        rst_n = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_hold_during_stall();
        clear_inputs();
        do_reset();
        m0_write = 1'b1; m0_address = 32'h0000_0500;
        m0_data_wr = 32'h1111_2222; m0_mask = 4'h3;
        s_stall = 1'b1;
        tick();
        m1_read = 1'b1; m1_address = 32'h0000_0600; m1_mask = 4'hC;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (s_address !== 32'h0000_0500) begin errors++; $display("[TB] FAIL hold_addr[%0d] got %0h want 500", i, s_address); end
            checks++; if (s_read !== 1'b0 || s_write !== 1'b1) begin errors++; $display("[TB] FAIL hold_strobes[%0d] got rd=%0h wr=%0h want 0 1", i, s_read, s_write); end
            checks++; if (s_mask !== 4'h3) begin errors++; $display("[TB] FAIL hold_mask[%0d] got %0h want 3", i, s_mask); end
            checks++; if (m1_stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_m1_stall[%0d] got %0h want 1", i, m1_stall); end
            tick();
        end
        s_stall = 1'b0;
        #1;
        checks++; if (m0_stall !== 1'b0) begin errors++; $display("[TB] FAIL hold_done_m0_stall got %0h want 0", m0_stall); end
        checks++; if (s_data_wr !== 32'h1111_2222) begin errors++; $display("[TB] FAIL hold_done_data got %0h want 11112222", s_data_wr); end
        tick();
        m0_write = 1'b0;
        #1;
        checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin errors++; $display("[TB] FAIL hold_idle_strobes got rd=%0h wr=%0h want 0 0", s_read, s_write); end
        tick();
        checks++; if (s_address !== 32'h0000_0600) begin errors++; $display("[TB] FAIL hold_m1_grant_addr got %0h want 600", s_address); end
        checks++; if (s_mask !== 4'hC) begin errors++; $display("[TB] FAIL hold_m1_grant_mask got %0h want c", s_mask); end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        test_reset();
        test_single_read();
        test_stalled_write();
        test_contention();
        test_abort();
        test_reset_in_grant();
        test_hold_during_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
